// File: rtl/gather.sv
// gather: joins one beat from the large-magnitude path with one beat from the
// small-magnitude path and emits their element-wise signed sum through a
// registered valid/ready output.
// Optional feature: define GATHER_SATURATE_EN to clamp each sum to the signed
// range; otherwise each sum wraps modulo 2^IN_WIDTH.
module gather #(
   parameter int IN_WIDTH       = 16,
   parameter int IN_SIZE        = 4,
   parameter int IN_PARALLELISM = 1
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic [IN_WIDTH*IN_SIZE*IN_PARALLELISM-1:0]    data_in_large,
   input  logic                                          data_in_large_valid,
   output logic                                          data_in_large_ready,
   input  logic [IN_WIDTH*IN_SIZE*IN_PARALLELISM-1:0]    data_in_small,
   input  logic                                          data_in_small_valid,
   output logic                                          data_in_small_ready,
   output logic [IN_WIDTH*IN_SIZE*IN_PARALLELISM-1:0]    data_out,
   output logic                                          data_out_valid,
   input  logic                                          data_out_ready
);

   localparam int N  = IN_SIZE * IN_PARALLELISM;
   localparam int DW = IN_WIDTH * N;

   // Join state is the pair of hold-register full flags {full_l, full_s}.
   typedef enum logic [1:0] {
      EMPTY  = 2'b00,
      HAVE_S = 2'b01,
      HAVE_L = 2'b10,
      BOTH   = 2'b11
   } join_state_e;

   join_state_e   state_q, state_d;
   logic [DW-1:0] hold_l_q, hold_l_d;
   logic [DW-1:0] hold_s_q, hold_s_d;
   logic [DW-1:0] out_q, out_d;
   logic          out_valid_q, out_valid_d;
   logic [DW-1:0] sum;

   logic          full_l, full_s;
   logic          join_fire;
   logic          acc_l, acc_s;
   logic          ready_l, ready_s;

`ifdef GATHER_SATURATE_EN
   localparam logic [IN_WIDTH-1:0] SAT_MAX = {1'b0, {(IN_WIDTH-1){1'b1}}};
   localparam logic [IN_WIDTH-1:0] SAT_MIN = {1'b1, {(IN_WIDTH-1){1'b0}}};
   logic [IN_WIDTH-1:0] el_a, el_b;
   logic [IN_WIDTH:0]   wide;
`endif

   // State register: join state, hold registers and output register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= EMPTY;
         hold_l_q    <= '0;
         hold_s_q    <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_l_q    <= hold_l_d;
         hold_s_q    <= hold_s_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Output/decode logic: full flags, join condition, readies and accepts.
   always_comb begin
      full_l    = state_q[1];
      full_s    = state_q[0];
      join_fire = full_l && full_s && (!out_valid_q || data_out_ready);
      // Readies are gated by reset so nothing is offered as accepted while it is held.
      ready_l   = rst && (!full_l || join_fire);
      ready_s   = rst && (!full_s || join_fire);
      acc_l     = data_in_large_valid && ready_l;
      acc_s     = data_in_small_valid && ready_s;
   end

   // Next-state logic: a full flag survives a join only if refilled in the same cycle.
   always_comb begin
      state_d     = join_state_e'({acc_l || (full_l && !join_fire),
                                   acc_s || (full_s && !join_fire)});
      hold_l_d    = acc_l ? data_in_large : hold_l_q;
      hold_s_d    = acc_s ? data_in_small : hold_s_q;
      out_d       = join_fire ? sum : out_q;
      out_valid_d = join_fire ? 1'b1
                  : ((out_valid_q && data_out_ready) ? 1'b0 : out_valid_q);
   end

   // Element-wise signed sum of the two hold registers.
   always_comb begin
      sum = '0;
`ifdef GATHER_SATURATE_EN
      el_a = '0;
      el_b = '0;
      wide = '0;
      for (int unsigned k = 0; k < N; k++) begin
         el_a = hold_l_q[k*IN_WIDTH +: IN_WIDTH];
         el_b = hold_s_q[k*IN_WIDTH +: IN_WIDTH];
         wide = {el_a[IN_WIDTH-1], el_a} + {el_b[IN_WIDTH-1], el_b};
         // Overflow when the extended sign disagrees with the result sign.
         if (wide[IN_WIDTH] != wide[IN_WIDTH-1])
            sum[k*IN_WIDTH +: IN_WIDTH] = wide[IN_WIDTH] ? SAT_MIN : SAT_MAX;
         else
            sum[k*IN_WIDTH +: IN_WIDTH] = wide[IN_WIDTH-1:0];
      end
`else
      for (int unsigned k = 0; k < N; k++) begin
         sum[k*IN_WIDTH +: IN_WIDTH] = hold_l_q[k*IN_WIDTH +: IN_WIDTH]
                                     + hold_s_q[k*IN_WIDTH +: IN_WIDTH];
      end
`endif
   end

   assign data_in_large_ready = ready_l;
   assign data_in_small_ready = ready_s;
   assign data_out            = out_q;
   assign data_out_valid      = out_valid_q;

endmodule

// File: tb/tb_gather.sv
// Bench for gather: queued beat drivers on both inputs, a shared expected-result
// queue, and an output monitor that pops and compares on every output transfer.
module tb_gather;

   localparam int W  = 16;
   localparam int N  = 4;
   localparam int DW = W * N;

   logic          clk;
   logic          rst;
   logic [DW-1:0] large_data, small_data, out_data;
   logic          large_valid, large_ready;
   logic          small_valid, small_ready;
   logic          out_valid, out_ready;

   gather #(.IN_WIDTH(W), .IN_SIZE(N), .IN_PARALLELISM(1)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .data_in_large       (large_data),
      .data_in_large_valid (large_valid),
      .data_in_large_ready (large_ready),
      .data_in_small       (small_data),
      .data_in_small_valid (small_valid),
      .data_in_small_ready (small_ready),
      .data_out            (out_data),
      .data_out_valid      (out_valid),
      .data_out_ready      (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [DW-1:0] lq[$];
   logic [DW-1:0] sq[$];
   logic [DW-1:0] exp_q[$];
   int  n_tests = 0;
   int  n_fail  = 0;
   int  pl      = 100;
   int  ps      = 100;
   int  or_mode = 1;   // 0: out_ready low, 1: high, 2: random
   bit  en_l    = 1'b1;
   bit  en_s    = 1'b1;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, expv);
      end
   endtask

   task automatic timeout(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out waiting", name);
   endtask

   task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] s, input logic [DW-1:0] e);
      lq.push_back(l);
      sq.push_back(s);
      exp_q.push_back(e);
   endtask

   function automatic logic [DW-1:0] model(input logic [DW-1:0] l, input logic [DW-1:0] s);
      logic [DW-1:0]   r;
      logic signed [15:0] ea, eb;
      int t;
      r = '0;
      for (int k = 0; k < N; k++) begin
         ea = l[k*W +: W];
         eb = s[k*W +: W];
         t  = int'(ea) + int'(eb);
`ifdef GATHER_SATURATE_EN
         if (t > 32767)       r[k*W +: W] = 16'h7FFF;
         else if (t < -32768) r[k*W +: W] = 16'h8000;
         else                 r[k*W +: W] = t[15:0];
`else
         r[k*W +: W] = t[15:0];
`endif
      end
      return r;
   endfunction

   // Large-path driver: holds each beat until accepted.
   initial begin : drv_large
      bit acc;
      large_valid = 1'b0;
      large_data  = '0;
      forever begin
         @(negedge clk);
         acc = large_valid && large_ready;
         @(posedge clk);
         #1;
         if (acc) large_valid = 1'b0;
         if (!large_valid && en_l && lq.size() > 0 && int'($urandom_range(99)) < pl) begin
            large_data  = lq.pop_front();
            large_valid = 1'b1;
         end
      end
   end

   // Small-path driver: holds each beat until accepted.
   initial begin : drv_small
      bit acc;
      small_valid = 1'b0;
      small_data  = '0;
      forever begin
         @(negedge clk);
         acc = small_valid && small_ready;
         @(posedge clk);
         #1;
         if (acc) small_valid = 1'b0;
         if (!small_valid && en_s && sq.size() > 0 && int'($urandom_range(99)) < ps) begin
            small_data  = sq.pop_front();
            small_valid = 1'b1;
         end
      end
   end

   // Consumer ready driver.
   initial begin : drv_ready
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (or_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = (int'($urandom_range(99)) < 70);
         endcase
      end
   end

   // Output monitor: compares each transferred beat and checks stability under stall.
   initial begin : monitor
      logic [DW-1:0] prev;
      bit stalled;
      stalled = 1'b0;
      prev    = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            stalled = 1'b0;
         end else begin
            if (stalled) begin
               check_bit("stall_valid", out_valid, 1'b1);
               check("stall_data", out_data, prev);
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_out: got %h expected none", out_data);
               end else begin
                  check("out_data", out_data, exp_q.pop_front());
               end
            end
            stalled = out_valid && !out_ready;
            prev    = out_data;
         end
      end
   end

   task automatic wait_accept_both(input string name);
      int i;
      for (i = 0; i < 200; i++) begin
         @(negedge clk);
         if (large_valid && large_ready && small_valid && small_ready) break;
      end
      if (i == 200) timeout(name);
   endtask

   task automatic wait_accept_l(input string name);
      int i;
      for (i = 0; i < 200; i++) begin
         @(negedge clk);
         if (large_valid && large_ready) break;
      end
      if (i == 200) timeout(name);
   endtask

   task automatic wait_accept_s(input string name);
      int i;
      for (i = 0; i < 200; i++) begin
         @(negedge clk);
         if (small_valid && small_ready) break;
      end
      if (i == 200) timeout(name);
   endtask

   task automatic wait_out_valid(input string name);
      int i;
      for (i = 0; i < 200; i++) begin
         @(negedge clk);
         if (out_valid) break;
      end
      if (i == 200) timeout(name);
   endtask

   task automatic wait_drain(input string name, input int bound);
      int i;
      for (i = 0; i < bound; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0) break;
      end
      if (i == bound) timeout(name);
   endtask

   initial begin : main
      rst = 1'b1;
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);

      // Reset state
      @(negedge clk);
      check_bit("rst_out_valid", out_valid, 1'b0);
      check("rst_data_out", out_data, '0);
      check_bit("rst_ready_l", large_ready, 1'b0);
      check_bit("rst_ready_s", small_ready, 1'b0);
      @(posedge clk);
      #3 rst = 1'b1;
      @(negedge clk);
      check_bit("empty_ready_l", large_ready, 1'b1);
      check_bit("empty_ready_s", small_ready, 1'b1);

      // Simultaneous pair: element0 3 + 5 = 8
      push(64'h0010_0020_0030_0003, 64'h0001_0002_0003_0005, 64'h0011_0022_0033_0008);
      wait_accept_both("simul_accept");
      @(negedge clk);
      check_bit("simul_valid_e", out_valid, 1'b0);
      check_bit("simul_ready_l", large_ready, 1'b1);
      check_bit("simul_ready_s", small_ready, 1'b1);
      @(negedge clk);
      check_bit("simul_valid_e1", out_valid, 1'b1);
      wait_drain("simul_drain", 200);

      // Skew: large runs ahead, second large pairs with second small
      en_s = 1'b0;
      push(64'h0000_0000_0000_0011, 64'h0000_0000_0000_0022, 64'h0000_0000_0000_0033);
      push(64'h0000_0000_0000_0100, 64'h0000_0000_0000_0200, 64'h0000_0000_0000_0300);
      wait_accept_l("skew_accept_l");
      repeat (3) begin
         @(negedge clk);
         check_bit("skew_ready_l", large_ready, 1'b0);
      end
      en_s = 1'b1;
      wait_accept_s("skew_accept_s");
      @(negedge clk);
      check_bit("skew_valid_e", out_valid, 1'b0);
      @(negedge clk);
      check_bit("skew_valid_e1", out_valid, 1'b1);
      wait_drain("skew_drain", 200);

      // Overflow corners
`ifdef GATHER_SATURATE_EN
      push(64'h7FFF_FFFE_8000_7000, 64'h8000_FFFD_FFFF_2000, 64'hFFFF_FFFB_8000_7FFF);
`else
      push(64'h7FFF_FFFE_8000_7000, 64'h8000_FFFD_FFFF_2000, 64'hFFFF_FFFB_7FFF_9000);
`endif
      wait_drain("ovf_drain", 200);

      // Backpressure: four pairs against a stalled consumer
      @(negedge clk);
      or_mode = 0;
      push({4{16'h0001}}, {4{16'h0010}}, {4{16'h0011}});
      push({4{16'h0002}}, {4{16'h0020}}, {4{16'h0022}});
      push({4{16'h0003}}, {4{16'h0030}}, {4{16'h0033}});
      push({4{16'h0004}}, {4{16'h0040}}, {4{16'h0044}});
      repeat (5) @(negedge clk);
      check_bit("bp_ready_l", large_ready, 1'b0);
      check_bit("bp_ready_s", small_ready, 1'b0);
      check_bit("bp_out_valid", out_valid, 1'b1);
      @(negedge clk);
      or_mode = 1;
      wait_drain("bp_drain", 200);

      // Reset mid-operation while HAVE_L with output valid
      @(negedge clk);
      or_mode = 0;
      push({4{16'h0005}}, {4{16'h0006}}, {4{16'h000B}});
      wait_out_valid("rm_first_valid");
      en_s = 1'b0;
      push({4{16'h0700}}, {4{16'h0800}}, {4{16'h0F00}});
      wait_accept_l("rm_accept_l");
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check_bit("rm_out_valid", out_valid, 1'b0);
      check_bit("rm_ready_l", large_ready, 1'b0);
      check_bit("rm_ready_s", small_ready, 1'b0);
      check("rm_data_out", out_data, '0);
      lq.delete();
      sq.delete();
      exp_q.delete();
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      en_s = 1'b1;
      @(negedge clk);
      or_mode = 1;
      push({4{16'h0001}}, {4{16'h0002}}, {4{16'h0003}});
      wait_drain("rm_fresh_drain", 200);

      // Random valid/ready on all handshakes
      pl      = 70;
      ps      = 70;
      or_mode = 2;
      for (int i = 0; i < 10000; i++) begin
         logic [DW-1:0] l, s;
         l = {$urandom, $urandom};
         s = {$urandom, $urandom};
         push(l, s, model(l, s));
      end
      wait_drain("rand_drain", 60000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
